// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encodings and control constants for counter variants
package counter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic DIR_UP       = 1'b0;
   localparam logic DIR_DN       = 1'b1;
   localparam logic MODE_WRAP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - programmable up/down counter with start/stop, load, limit and wrap/one-shot modes
module mode_counter
   import counter_pkg::*;
#(
   parameter int                WIDTH   = 4,
   parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   input  logic [WIDTH-1:0] limit,
   input  logic             mode,
   output logic [WIDTH-1:0] c,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   logic [WIDTH-1:0] r_c;
   logic             r_tc;
   logic             w_term;

   assign w_term = (dir == DIR_DN) ? (r_c == '0) : (r_c == limit);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_c     <= RST_VAL;
         r_tc    <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (load) begin
            // load owns the counter value; a simultaneous stop still leaves RUN
            r_c <= load_val;
            if ((r_state == ST_DONE) || (stop && (r_state == ST_RUN)))
               r_state <= ST_IDLE;
         end else if (stop && (r_state == ST_RUN)) begin
            r_state <= ST_IDLE;
         end else if (start && (r_state != ST_RUN)) begin
            r_state <= ST_RUN;
         end else if ((r_state == ST_RUN) && en) begin
            if (w_term) begin
               r_tc <= 1'b1;
               if (mode == MODE_ONESHOT)
                  r_state <= ST_DONE;
               else
                  r_c <= (dir == DIR_DN) ? limit : '0;
            end else begin
               r_c <= (dir == DIR_DN) ? (r_c - WIDTH'(1)) : (r_c + WIDTH'(1));
            end
         end
      end
   end

   assign c    = r_c;
   assign tc   = r_tc;
   assign busy = (r_state == ST_RUN);
   assign done = (r_state == ST_DONE);

endmodule
